// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only instruction cache sitting between
// the core's fetch stage and main memory.  A hit returns the instruction
// combinationally in the same cycle as PCF.  A miss raises istall and pulls
// the whole line from memory one word at a time, always word 0 first.
//
// Ports:
//   clk, reset     - rising-edge clock, synchronous active-high reset
//   PCF            - fetch byte address from the core (bits [1:0] ignored)
//   InstrF         - instruction for PCF on a hit, zero otherwise
//   istall         - high while InstrF is not valid for PCF (low in reset)
//   InvalidateAll  - clears every valid bit and aborts any fill in progress
//   MemReadReq     - word read request to memory, held until MemRValid
//   MemAddr        - word-aligned address of the requested word
//   MemRData       - returned word
//   MemRValid      - MemRData valid, completes the current request
module icache_direct #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  output logic [31:0] InstrF,
  output logic        istall,
  input  logic        InvalidateAll,
  output logic        MemReadReq,
  output logic [31:0] MemAddr,
  input  logic [31:0] MemRData,
  input  logic        MemRValid
);

  localparam int OFF_W  = $clog2(WORDS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int LINE_W = 30 - OFF_W;
  localparam int TAG_W  = LINE_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(WORDS - 1);

  typedef enum logic {READY, FILL} state_t;

  state_t state, next_state;

  logic [LINE_W-1:0] miss_line;
  logic [OFF_W-1:0]  cnt;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [31:0]       data_mem [LINES][WORDS];

  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] miss_index;
  logic [TAG_W-1:0] miss_tag;

  logic hit;
  logic start_miss;
  logic beat_accept;
  logic last_beat;

  // The byte-offset bits of PCF carry no information for word fetches.
  logic unused_pcf_bits;
  assign unused_pcf_bits = ^PCF[1:0];

  assign offset     = PCF[OFF_W+1:2];
  assign index      = PCF[OFF_W+IDX_W+1:OFF_W+2];
  assign tag        = PCF[31:OFF_W+IDX_W+2];
  assign miss_index = miss_line[IDX_W-1:0];
  assign miss_tag   = miss_line[LINE_W-1:IDX_W];

  // InvalidateAll forces a miss in its own cycle so a stale line can never
  // be served while the valid bits are being wiped.
  assign hit = (state == READY) && valid[index] && (tag_mem[index] == tag)
               && !InvalidateAll;

  always_comb begin
    istall     = reset ? 1'b0 : !hit;
    InstrF     = hit ? data_mem[index][offset] : 32'h0;
    MemReadReq = (state == FILL) && !reset;
    MemAddr    = {miss_line, cnt, 2'b00};
  end

  // Next-state logic.  During FILL only the latched miss line matters, so
  // PCF may wander without disturbing the fill.  An invalidate during FILL
  // abandons the line, including any word that arrives in that same cycle.
  always_comb begin
    next_state  = state;
    start_miss  = 1'b0;
    beat_accept = 1'b0;
    last_beat   = 1'b0;
    case (state)
      READY: begin
        if (!hit) begin
          next_state = FILL;
          start_miss = 1'b1;
        end
      end
      FILL: begin
        if (InvalidateAll) begin
          next_state = READY;
        end else if (MemRValid) begin
          beat_accept = 1'b1;
          if (cnt == LAST_CNT) begin
            last_beat  = 1'b1;
            next_state = READY;
          end
        end
      end
      default: next_state = READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= READY;
      cnt   <= '0;
      valid <= '0;
    end else begin
      state <= next_state;
      if (InvalidateAll) begin
        valid <= '0;
      end else if (last_beat) begin
        valid[miss_index] <= 1'b1;
      end
      if (start_miss) begin
        cnt <= '0;
      end else if (beat_accept) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Tag and data storage carry no reset; the valid bits alone decide
  // whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (!reset && start_miss) begin
      miss_line <= PCF[31:OFF_W+2];
    end
    if (!reset && beat_accept) begin
      data_mem[miss_index][cnt] <= MemRData;
    end
    if (!reset && last_beat) begin
      tag_mem[miss_index] <= miss_tag;
    end
  end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the pipelined core's fetch stage and main memory.
- Serves InstrF for PCF combinationally on a hit.
- On a miss, raises istall and fills the whole line from memory using a word-serial request/valid handshake.
- It is the upstream producer of the core's InstrF and istall inputs.

Parameters:
LINES, 16, number of cache lines (power of 2, >=2)
WORDS, 4, 32-bit words per line (power of 2, >=2)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
PCF  input  32  fetch address from core (byte address, bits[1:0] ignored)
InstrF  output  32  instruction word for PCF
istall  output  1  high when InstrF is not valid for the current PCF
InvalidateAll  input  1  clears all valid bits (self-modifying code / boot)
MemReadReq  output  1  word read request to memory
MemAddr  output  32  word-aligned address of requested word
MemRData  input  32  returned word
MemRValid  input  1  MemRData valid; completes the current request

Behaviour:
- Address split:
  - offset = PCF[log2(WORDS)+1:2]
  - index = next log2(LINES) bits
  - tag = remaining upper bits
- Storage: per line a valid bit, a tag, and WORDS data words. Data and tag arrays are not reset; valid bits are.
- Hit (combinational) = state READY && valid[index] && tag[index]==tag(PCF) && !InvalidateAll.
  - InstrF = data[index][offset] on hit, 32'h0 otherwise.
  - istall = !hit, except forced 0 while reset is high.
- FSM states: READY, FILL.
- READY:
  - On miss, latch MissLine = PCF[31:log2(WORDS)+2] and clear beat counter cnt=0.
  - Next state FILL. The miss is detected in the same cycle, so istall is already 1.
- FILL:
  - MemReadReq=1 and MemAddr={MissLine, cnt, 2'b00}. MemAddr stays stable until MemRValid.
  - Each cycle with MemRValid=1: write MemRData into data[MissIndex][cnt]; cnt++.
  - When MemRValid=1 and cnt==WORDS-1: write the tag, set valid[MissIndex], and go to READY.
  - MemRValid while in READY is ignored.
- Fill order is always word 0..WORDS-1 (no critical-word-first).
- Miss penalty: with single-cycle memory (MemRValid high every FILL cycle), istall is high for WORDS+1 cycles:
  - 1 cycle for the miss cycle itself.
  - WORDS cycles in FILL.
  - The cycle after the last beat is a READY hit.
- The core holds PCF stable while istall=1. The cache uses only the latched MissLine during FILL, so a PCF change during FILL does not corrupt the fill. The refetch after FILL is looked up with the current PCF.
- InvalidateAll:
  - All valid bits are cleared at the clock edge. It also forces a miss in that cycle.
  - If asserted in FILL: the fill is aborted at that edge. The state returns to READY and MemReadReq drops next cycle. The partially written line stays invalid, and a word accepted in that same cycle is discarded.
  - The memory must tolerate request withdrawal; a MemRValid arriving with MemReadReq low is ignored.
- Reset:
  - Clears all valid bits, state=READY, cnt=0.
  - MemReadReq=0 and istall=0 during and after reset; after reset istall follows the hit logic.
  - Reset mid-FILL aborts the fill with the same line invalidation as InvalidateAll.
- Index aliasing: a miss to a valid line with a different tag overwrites it. There is no write-back; the cache is read-only.

Test Plan:
- Reset then PCF=0x00000000, single-cycle memory returning word n = 0xE000_0000+n -> istall high 5 cycles; MemAddr 0x0,0x4,0x8,0xC; then InstrF=0xE0000000, istall=0.
- After that fill, PCF=0x8 -> hit the same cycle, InstrF=0xE0000002, MemReadReq=0.
- PCF=0x100 (index 0, new tag) after line 0 is filled -> miss, refill from 0x100..0x10C; then PCF=0x0 misses again (eviction confirmed).
- Memory with 3-cycle latency per word, PCF=0x40 -> MemAddr held 3 cycles per beat; istall high 1+12 cycles; correct data at each offset.
- InvalidateAll pulsed on the second FILL beat of PCF=0x80 -> MemReadReq low next cycle; refetch of 0x80 restarts the fill at word 0; a previously valid line 0 now misses.
- reset asserted mid-FILL, then PCF=0x0 -> istall=0 during reset; after reset a full 4-beat fill starts from 0x0.
